mmu_req_sync_buffer: RTL and testbench
======================================

Name: mmu_req_sync_buffer

Overview:
- Downstream neighbour of the single-token asynchronous MMU FIFO stage.
- Takes its two-phase drive output and the bundled request data into the clocked MMU domain through a multi-flop synchronizer.
- Buffers requests in a small circular FIFO and presents them to the synchronous TLB lookup on a valid/ready interface.
- Returns a two-phase free toggle upstream each time a request has been captured.

Parameters:
- DATA_W, 52, width of the bundled request (vaddr + asid + attr bits).
- DEPTH, 4, FIFO entries; power of 2, at least 2.

Ports:
- clk  input  1  single clock of the MMU synchronous domain.
- rst  input  1  synchronous reset, active-high.
- i_drive  input  1  two-phase request from upstream; each transition is one token; asynchronous to clk.
- i_data  input  DATA_W  bundled request data; held stable from the i_drive transition until the matching o_free transition.
- o_free  output  1  two-phase acknowledge to upstream; toggles once per captured token.
- o_valid  output  1  FIFO head valid.
- o_data  output  DATA_W  FIFO head data.
- i_ready  input  1  consumer accepts head when o_valid and i_ready are both high.
- o_level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset, synchronous and active-high:
  - sync flops = 0, drv_seen = 0, o_free = 0.
  - Read and write pointers = 0, o_level = 0, o_valid = 0.
  - o_data holds don't-care; the bench must not check it while o_valid is 0.
- Synchronizer: i_drive passes through 2 flops (sync1 → sync2). No other logic may sample i_drive.
- Token detection: token_pend = sync2 XOR drv_seen (combinational).
- Write condition: token_pend and (o_level < DEPTH, or (o_level == DEPTH and o_valid and i_ready)).
- On a write, at the clock edge:
  - mem[wr_ptr] <= i_data.
  - wr_ptr increments modulo DEPTH.
  - drv_seen <= sync2.
  - o_free toggles.
- i_data is sampled only in the write cycle. Upstream cannot change it earlier because o_free has not yet toggled.
- Read: on o_valid and i_ready, rd_ptr increments modulo DEPTH.
- Head presentation: o_data = mem[rd_ptr] (registered memory, combinational read); o_valid = (o_level != 0).
- Occupancy: o_level increments on write only, decrements on read only, and is unchanged on simultaneous write and read.
- Latency: with setup met before edge E0:
  - sync1 updates at E0, sync2 at E1.
  - The write happens at E2, so o_valid and the o_free toggle are visible after E2.
  - Empty-to-output latency is 3 clocks.
- Full: the token stays pending and o_free does not toggle. Upstream therefore stalls naturally.
  - Capture happens in the first cycle that a slot frees, including the pop cycle itself (full plus pop plus pending token: write and read in the same cycle, level stays DEPTH).
- Back-to-back tokens: upstream issues no new transition before o_free toggles, so at most one token is pending. A second transition arriving while one is pending is a protocol violation and has no defined response.
- Pointer wrap: pointers are $clog2(DEPTH) bits with natural rollover. Full and empty are distinguished by o_level only.
- Reset mid-operation:
  - All buffered and pending tokens are discarded.
  - The upstream async stage is reset in the same window, so its drive phase also returns to 0. Otherwise a spurious token appears.
  - o_free returns to 0 the cycle after rst is sampled high.
- No combinational path from i_drive or i_data to any output. o_free is a flop output.

Optional Feature:
- MMU_REQ_SYNC_3FF_EN
- Defined:
  - The synchronizer is 3 flops (sync1 → sync2 → sync3), and detection uses sync3.
  - Empty-to-output latency is 4 clocks.
  - All other behaviour is unchanged.
- Undefined: 2-flop synchronizer, 3-clock latency, as above.

Test Plan:
- Single token: after reset, toggle i_drive 0→1 with i_data=52'h0_1234_5678_9AB and i_ready=0. Expect:
  - o_valid=1 and o_data=52'h0_1234_5678_9AB exactly 3 clocks later.
  - o_free=1 in the same cycle.
  - o_level=1.
- Fill and stall: issue 5 handshaked tokens (data 1..5) with i_ready=0. Expect:
  - o_level=4 and exactly 4 o_free toggles.
  - The 5th token stays pending and o_free stays at its 4th-toggle value.
- Full release: from the full state, pulse i_ready for 1 cycle. Expect:
  - Data 1 is popped.
  - Data 5 is written in the same cycle, o_level stays 4, and o_free toggles a 5th time.
  - A subsequent drain yields 2,3,4,5 in order and o_level reaches 0.
- Streaming wrap: hold i_ready=1 and run 10 handshaked tokens (data 0xA0..0xA9). Expect:
  - All 10 emerge in order and pointers wrap twice.
  - o_level never exceeds 1.
- Reset mid-stream: with 3 entries buffered and 1 token pending, assert rst for 1 cycle while upstream is also reset. Expect:
  - o_valid=0, o_level=0, o_free=0 the next cycle.
  - No stale entry appears afterwards.
- Feature build: with MMU_REQ_SYNC_3FF_EN defined, repeat the single-token scenario. Expect o_valid and the o_free toggle 4 clocks after the i_drive toggle.

Source files
------------

// File: rtl/mmu_req_sync_buffer.sv
// mmu_req_sync_buffer
//   Brings two-phase request tokens from the asynchronous MMU FIFO stage into
//   the clocked MMU domain. The tokens are buffered in a small circular FIFO and
//   presented to the TLB lookup on a valid/ready interface.
//
//   A multi-flop synchronizer carries i_drive into the domain. A token is
//   pending while the synchronized drive phase differs from drv_seen. The
//   token is captured when a slot is free, and each capture toggles o_free.
//
// Configuration:
//   MMU_REQ_SYNC_3FF_EN  when defined, the synchronizer has 3 flops instead of 2
//                        (empty-to-output latency 4 clocks instead of 3).
//
// Ports:
//   clk      clock of the MMU synchronous domain
//   rst      synchronous active-high reset
//   i_drive  two-phase request from upstream (asynchronous)
//   i_data   bundled request data; stable until the matching o_free toggle
//   o_free   two-phase acknowledge; toggles once per captured token
//   o_valid  FIFO head valid
//   o_data   FIFO head data
//   i_ready  consumer accepts the head when o_valid && i_ready
//   o_level  occupancy, 0..DEPTH
module mmu_req_sync_buffer #(
    parameter int unsigned DATA_W = 52,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_drive,
    input  logic [DATA_W-1:0]          i_data,
    output logic                       o_free,
    output logic                       o_valid,
    output logic [DATA_W-1:0]          o_data,
    input  logic                       i_ready,
    output logic [$clog2(DEPTH):0]     o_level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

`ifdef MMU_REQ_SYNC_3FF_EN
    localparam int unsigned SYNC_N = 3;
`else
    localparam int unsigned SYNC_N = 2;
`endif

    // sync_q[0] is the only flop that samples i_drive.
    logic [SYNC_N-1:0] sync_q;
    logic              sync_out;
    logic              drv_seen_q;
    logic              free_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [LVL_W-1:0]  level_q;
    logic [LVL_W-1:0]  level_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic token_pend;
    logic rd_en;
    logic wr_en;

    assign sync_out   = sync_q[SYNC_N-1];
    assign token_pend = sync_out ^ drv_seen_q;
    assign o_valid    = (level_q != '0);
    assign rd_en      = o_valid && i_ready;
    // When full, a pending token can still be captured in the cycle that pops the head.
    assign wr_en      = token_pend && ((level_q != LVL_FULL) || rd_en);

    assign o_data  = mem_q[rd_ptr_q];
    assign o_level = level_q;
    assign o_free  = free_q;

    always_comb begin
        level_d = level_q;
        unique case ({wr_en, rd_en})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= '0;
            drv_seen_q <= 1'b0;
            free_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_N-2:0], i_drive};
            level_q <= level_d;
            if (wr_en) begin
                wr_ptr_q   <= wr_ptr_q + PTR_W'(1);
                drv_seen_q <= sync_out;
                free_q     <= ~free_q;
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Storage needs no reset; o_valid masks stale contents.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

endmodule

// File: tb/tb_mmu_req_sync_buffer.sv
module tb_mmu_req_sync_buffer;

`ifdef MMU_REQ_SYNC_3FF_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic        clk;
    logic        rst;
    logic        i_drive;
    logic [51:0] i_data;
    logic        o_free;
    logic        o_valid;
    logic [51:0] o_data;
    logic        i_ready;
    logic [2:0]  o_level;

    int checks   = 0;
    int failures = 0;
    logic free_exp;
    int max_lvl;
    logic [51:0] popped [$];

    mmu_req_sync_buffer #(
        .DATA_W(52),
        .DEPTH (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .i_drive(i_drive),
        .i_data (i_data),
        .o_free (o_free),
        .o_valid(o_valid),
        .o_data (o_data),
        .i_ready(i_ready),
        .o_level(o_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: record any pop the coming edge performs, then sample 1 time unit after it.
    task automatic tick();
        if (o_valid === 1'b1 && i_ready === 1'b1) popped.push_back(o_data);
        @(posedge clk);
        #1;
        if (int'(o_level) > max_lvl) max_lvl = int'(o_level);
    endtask

    // Issue one token; optionally wait (bounded) for its o_free acknowledge.
    task automatic send(input string tag, input logic [51:0] d, input bit wait_ack);
        int n;
        i_data  = d;
        i_drive = ~i_drive;
        if (wait_ack) begin
            n = 0;
            while (o_free === free_exp && n < 20) begin
                tick();
                n++;
            end
            free_exp = ~free_exp;
            check(tag, {63'd0, o_free}, {63'd0, free_exp});
        end
    endtask

    initial begin
        rst      = 1'b1;
        i_drive  = 1'b0;
        i_data   = '0;
        i_ready  = 1'b0;
        free_exp = 1'b0;
        max_lvl  = 0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_valid", {63'd0, o_valid}, 64'd0);
        check("rst_level", {61'd0, o_level}, 64'd0);
        check("rst_free", {63'd0, o_free}, 64'd0);

        // Single token: visible exactly LAT clocks after the drive toggle.
        i_data  = 52'h0_1234_5678_9AB;
        i_drive = 1'b1;
        for (int k = 1; k < LAT; k++) begin
            tick();
            check("lat_early_valid", {63'd0, o_valid}, 64'd0);
            check("lat_early_free", {63'd0, o_free}, 64'd0);
        end
        tick();
        free_exp = 1'b1;
        check("single_valid", {63'd0, o_valid}, 64'd1);
        check("single_data", {12'd0, o_data}, {12'd0, 52'h0_1234_5678_9AB});
        check("single_free", {63'd0, o_free}, 64'd1);
        check("single_level", {61'd0, o_level}, 64'd1);
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        check("single_pop_level", {61'd0, o_level}, 64'd0);

        // Fill to full, fifth token stalls.
        for (int v = 1; v <= 4; v++) send("fill_ack", 52'(v), 1'b1);
        check("fill_level", {61'd0, o_level}, 64'd4);
        check("fill_free", {63'd0, o_free}, {63'd0, free_exp});
        send("fill5", 52'd5, 1'b0);
        for (int k = 0; k < 8; k++) tick();
        check("stall_free", {63'd0, o_free}, {63'd0, free_exp});
        check("stall_level", {61'd0, o_level}, 64'd4);
        check("stall_head", {12'd0, o_data}, 64'd1);

        // Full release: pop and capture in the same cycle.
        i_ready = 1'b1;
        tick();
        i_ready  = 1'b0;
        free_exp = ~free_exp;
        check("release_level", {61'd0, o_level}, 64'd4);
        check("release_free", {63'd0, o_free}, {63'd0, free_exp});
        check("release_head", {12'd0, o_data}, 64'd2);
        i_ready = 1'b1;
        for (int v = 2; v <= 5; v++) begin
            check("drain_valid", {63'd0, o_valid}, 64'd1);
            check("drain_data", {12'd0, o_data}, 64'(v));
            tick();
        end
        i_ready = 1'b0;
        check("drain_level", {61'd0, o_level}, 64'd0);
        check("drain_valid_end", {63'd0, o_valid}, 64'd0);

        // Streaming with pointer wrap.
        popped.delete();
        max_lvl = 0;
        i_ready = 1'b1;
        for (int v = 0; v < 10; v++) send("stream_ack", 52'(8'hA0 + v), 1'b1);
        for (int k = 0; k < 4; k++) tick();
        check("stream_count", 64'(popped.size()), 64'd10);
        for (int v = 0; v < 10; v++) begin
            if (v < popped.size()) check("stream_data", {12'd0, popped[v]}, 64'(8'hA0 + v));
        end
        check("stream_maxlvl", 64'(max_lvl), 64'd1);
        check("stream_level_end", {61'd0, o_level}, 64'd0);
        i_ready = 1'b0;

        // Reset mid-stream: 3 buffered, 1 pending.
        for (int v = 1; v <= 3; v++) send("mid_ack", 52'(8'h30 + v), 1'b1);
        send("mid_pend", 52'h34, 1'b0);
        tick();
        check("mid_level", {61'd0, o_level}, 64'd3);
        rst     = 1'b1;
        i_drive = 1'b0;
        tick();
        rst      = 1'b0;
        free_exp = 1'b0;
        check("mrst_valid", {63'd0, o_valid}, 64'd0);
        check("mrst_level", {61'd0, o_level}, 64'd0);
        check("mrst_free", {63'd0, o_free}, 64'd0);
        for (int k = 0; k < 8; k++) tick();
        check("post_rst_valid", {63'd0, o_valid}, 64'd0);
        check("post_rst_level", {61'd0, o_level}, 64'd0);
        check("post_rst_free", {63'd0, o_free}, 64'd0);
        send("post_rst_ack", 52'h77, 1'b1);
        check("post_rst_data", {12'd0, o_data}, 64'h77);
        check("post_rst_level1", {61'd0, o_level}, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
